// File: rtl/rgb_wheel_scheduler.sv
// Shared timebase, hue sequencer and 3-channel PWM for the RGB colour-wheel animation.
// Optional button/debounce/mode machine is built only when RGB_WHEEL_BUTTON_EN is defined.
//
// mode       | meaning
// -----------+--------------------------------------------------------
// RUN   (0)  | timebase, hue and duties advance; PWM outputs active
// PAUSE (1)  | timebase, hue and duties frozen; PWM runs at held duties
// BLANK (2)  | animation advances; all PWM outputs forced low
module rgb_wheel_scheduler #(
    parameter int INC_DEC_INTERVAL = 10_000,
    parameter int INC_DEC_MAX      = 200,
    parameter int STATE_COUNT      = 6,
    parameter int PWM_INTERVAL     = 1200,
    parameter int STEP_VAL         = 6,
    parameter int DEBOUNCE_CYCLES  = 120_000,
    parameter int DW               = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn_n,
    output logic          pwm_r,
    output logic          pwm_g,
    output logic          pwm_b,
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    hue_state,
    output logic [1:0]    mode,
    output logic          tick
);

    localparam int PSW = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
    localparam int TCW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_PAUSE = 2'd1;
    localparam logic [1:0] MODE_BLANK = 2'd2;

    localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] DUTY_STEP = DW'(STEP_VAL);

    logic [PSW-1:0] presc_q, presc_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]     hue_q, hue_d;
    logic [DW-1:0]  duty_q [3];
    logic [DW-1:0]  duty_d [3];
    logic [DW-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [2:0]     pwm_q, pwm_d;
    logic           advance;
    logic           tick_w;
    logic           last_tick;
    logic [1:0]     mode_w;

    function automatic int unsigned chan_offset(input int ch);
        case (ch)
            0:       return 4;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] phase_of(input logic [2:0] hue, input int unsigned off);
        int unsigned s;
        s = 32'(hue) + off;
        return 3'(s % 6);
    endfunction

    function automatic logic [DW-1:0] duty_start(input logic [2:0] p);
        case (p)
            3'd1, 3'd2, 3'd3: return DUTY_MAX;
            default:          return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] duty_step(input logic [2:0] p, input logic [DW-1:0] cur);
        logic [DW:0] up;
        up = {1'b0, cur} + {1'b0, DUTY_STEP};
        case (p)
            3'd0:    return (up > {1'b0, DUTY_MAX}) ? DUTY_MAX : up[DW-1:0];
            3'd3:    return (cur < DUTY_STEP) ? '0 : cur - DUTY_STEP;
            default: return cur;
        endcase
    endfunction

`ifdef RGB_WHEEL_BUTTON_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic           sync1_q, sync2_q;
    logic           deb_q, deb_d;
    logic           deb_prev_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           press;

    // A press is the debounced level falling; release is ignored.
    assign press = deb_prev_q & ~deb_q;

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            case (mode_q)
                MODE_RUN:   mode_d = MODE_PAUSE;
                MODE_PAUSE: mode_d = MODE_BLANK;
                default:    mode_d = MODE_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            db_cnt_q   <= '0;
            mode_q     <= MODE_RUN;
        end else begin
            sync1_q    <= btn_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode_d;
        end
    end

    assign mode_w = mode_q;
`else
    logic unused_btn_n;
    assign unused_btn_n = btn_n;
    assign mode_w       = MODE_RUN;
`endif

    assign advance   = (mode_w != MODE_PAUSE);
    assign tick_w    = advance && (presc_q == PSW'(INC_DEC_INTERVAL - 1));
    assign last_tick = (tick_cnt_q == TCW'(INC_DEC_MAX - 1));

    always_comb begin
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        hue_d      = hue_q;
        for (int i = 0; i < 3; i++) duty_d[i] = duty_q[i];

        if (advance) begin
            presc_d = tick_w ? '0 : presc_q + PSW'(1);
        end

        // A hue advance snaps every channel to its new phase start, overriding the ramp.
        if (tick_w) begin
            if (last_tick) begin
                tick_cnt_d = '0;
                hue_d      = (hue_q == 3'(STATE_COUNT - 1)) ? 3'd0 : hue_q + 3'd1;
                for (int i = 0; i < 3; i++)
                    duty_d[i] = duty_start(phase_of(hue_d, chan_offset(i)));
            end else begin
                tick_cnt_d = tick_cnt_q + TCW'(1);
                for (int i = 0; i < 3; i++)
                    duty_d[i] = duty_step(phase_of(hue_q, chan_offset(i)), duty_q[i]);
            end
        end
    end

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == DW'(PWM_INTERVAL - 1)) ? '0 : pwm_cnt_q + DW'(1);
        for (int i = 0; i < 3; i++)
            pwm_d[i] = (pwm_cnt_q < duty_q[i]) && (mode_w != MODE_BLANK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tick_cnt_q <= '0;
            hue_q      <= 3'd0;
            pwm_cnt_q  <= '0;
            pwm_q      <= 3'b000;
            for (int i = 0; i < 3; i++)
                duty_q[i] <= duty_start(phase_of(3'd0, chan_offset(i)));
        end else begin
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            hue_q      <= hue_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            for (int i = 0; i < 3; i++)
                duty_q[i] <= duty_d[i];
        end
    end

    assign duty_r    = duty_q[0];
    assign duty_g    = duty_q[1];
    assign duty_b    = duty_q[2];
    assign pwm_r     = pwm_q[0];
    assign pwm_g     = pwm_q[1];
    assign pwm_b     = pwm_q[2];
    assign hue_state = hue_q;
    assign mode      = mode_w;
    assign tick      = tick_w;

endmodule

// File: tb/tb_rgb_wheel_scheduler.sv
// Self-checking bench for rgb_wheel_scheduler: directed and random button stimulus
// compared every cycle against a closed-form model of the wheel, PWM and mode sequence.
module tb_rgb_wheel_scheduler;

    localparam int IV = 4;
    localparam int MX = 5;
    localparam int SC = 6;
    localparam int PI = 10;
    localparam int ST = 2;
    localparam int DB = 3;
    localparam int DW = $clog2(PI + 1);

`ifdef RGB_WHEEL_BUTTON_EN
    localparam bit BTN_EN = 1'b1;
`else
    localparam bit BTN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_n;
    logic          pwm_r, pwm_g, pwm_b;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic [2:0]    hue_state;
    logic [1:0]    mode;
    logic          tick;

    int errors = 0;
    int checks = 0;

    rgb_wheel_scheduler #(
        .INC_DEC_INTERVAL(IV),
        .INC_DEC_MAX     (MX),
        .STATE_COUNT     (SC),
        .PWM_INTERVAL    (PI),
        .STEP_VAL        (ST),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    (btn_n),
        .pwm_r    (pwm_r),
        .pwm_g    (pwm_g),
        .pwm_b    (pwm_b),
        .duty_r   (duty_r),
        .duty_g   (duty_g),
        .duty_b   (duty_b),
        .hue_state(hue_state),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed running cycles and total ticks define everything.
    int m_elapsed, m_ticks, m_cyc, m_mode;
    int m_deb, m_deb_prev, m_diff, m_s1, m_s2;
    int m_pwm [3];

    task automatic m_reset();
        m_elapsed = 0; m_ticks = 0; m_cyc = 0; m_mode = 0;
        m_deb = 1; m_deb_prev = 1; m_diff = 0; m_s1 = 1; m_s2 = 1;
        for (int i = 0; i < 3; i++) m_pwm[i] = 0;
    endtask

    function automatic int m_hue();
        return (m_ticks / MX) % SC;
    endfunction

    function automatic int m_duty(input int ch);
        int off, k, p;
        off = (ch == 0) ? 4 : (ch == 1) ? 2 : 0;
        k   = m_ticks % MX;
        p   = (m_hue() + off) % 6;
        case (p)
            0:       return (k * ST > PI) ? PI : k * ST;
            1, 2:    return PI;
            3:       return (k * ST > PI) ? 0 : PI - k * ST;
            default: return 0;
        endcase
    endfunction

    function automatic int m_tick();
        return (m_mode != 1 && (m_elapsed % IV) == IV - 1) ? 1 : 0;
    endfunction

    task automatic m_edge(input logic r, input logic b);
        int d [3];
        int t, pc, press;
        if (!r) begin
            m_reset();
        end else begin
            t  = m_tick();
            pc = m_cyc % PI;
            for (int i = 0; i < 3; i++) begin
                d[i]     = m_duty(i);
                m_pwm[i] = (pc < d[i] && m_mode != 2) ? 1 : 0;
            end
            m_cyc++;
            if (m_mode != 1) begin
                m_elapsed++;
                if (t != 0) m_ticks++;
            end
            if (BTN_EN) begin
                press      = (m_deb_prev == 1 && m_deb == 0) ? 1 : 0;
                m_deb_prev = m_deb;
                if (m_s2 != m_deb) begin
                    m_diff++;
                    if (m_diff == DB) begin
                        m_deb  = m_s2;
                        m_diff = 0;
                    end
                end else begin
                    m_diff = 0;
                end
                m_s2 = m_s1;
                m_s1 = b ? 1 : 0;
                if (press != 0) m_mode = (m_mode + 1) % 3;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("duty_r", 32'(duty_r), m_duty(0));
        chk("duty_g", 32'(duty_g), m_duty(1));
        chk("duty_b", 32'(duty_b), m_duty(2));
        chk("hue_state", 32'(hue_state), m_hue());
        chk("mode", 32'(mode), m_mode);
        chk("tick", 32'(tick), m_tick());
        chk("pwm_r", 32'(pwm_r), m_pwm[0]);
        chk("pwm_g", 32'(pwm_g), m_pwm[1]);
        chk("pwm_b", 32'(pwm_b), m_pwm[2]);
    endtask

    task automatic cyc(input logic r, input logic b);
        @(negedge clk);
        rst_n = r;
        btn_n = b;
        @(posedge clk);
        m_edge(r, b);
        #1;
        check_all();
    endtask

    int min_g;
    int n;
    bit found;

    initial begin
        m_reset();
        rst_n = 1'b0;
        btn_n = 1'b1;

        // reset and first PWM cycle
        repeat (3) cyc(1'b0, 1'b1);
        chk("rst_duty_g", 32'(duty_g), 32'd10);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_pwm_g", 32'(pwm_g), 32'd0);
        cyc(1'b1, 1'b1);
        chk("first_pwm_g", 32'(pwm_g), 32'd1);
        chk("first_pwm_r", 32'(pwm_r), 32'd0);
        chk("first_pwm_b", 32'(pwm_b), 32'd0);

        // ramp through the first hue state
        repeat (3) cyc(1'b1, 1'b1);
        chk("ramp_b_first", 32'(duty_b), 32'd2);
        repeat (16) cyc(1'b1, 1'b1);
        chk("ramp_hue1", 32'(hue_state), 32'd1);
        chk("ramp_b_snap", 32'(duty_b), 32'd10);
        chk("ramp_g_hold", 32'(duty_g), 32'd10);
        chk("ramp_r_zero", 32'(duty_r), 32'd0);

        // full wheel wrap
        min_g = PI;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b1);
            if (int'(duty_g) < min_g) min_g = int'(duty_g);
        end
        chk("wrap_hue", 32'(hue_state), 32'd0);
        chk("wrap_duty_r", 32'(duty_r), 32'd0);
        chk("wrap_duty_g", 32'(duty_g), 32'd10);
        chk("wrap_duty_b", 32'(duty_b), 32'd0);
        chk("wrap_g_min", 32'(min_g), 32'd0);

        // short glitch, then a long press into PAUSE
        repeat (2) cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b0);

        // BLANK, then back to RUN
        repeat (10) cyc(1'b1, 1'b1);
        repeat (10) cyc(1'b1, 1'b0);
        repeat (30) cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b1, 1'b1);
        repeat (10) cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b1, 1'b1);

        // random bounce and random hold lengths
        repeat (60) cyc(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) begin
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            n   = int'($urandom_range(1, 8));
            repeat (n) cyc(1'b1, lvl);
        end
        repeat (10) cyc(1'b1, 1'b1);

        // return to RUN, reach hue 3, pause, then reset
        for (int i = 0; i < 4 && m_mode != 0; i++) begin
            repeat (10) cyc(1'b1, 1'b0);
            repeat (10) cyc(1'b1, 1'b1);
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(1'b1, 1'b1);
            if (m_hue() == 3) found = 1'b1;
        end
        chk("reach_hue3", 32'(found), 32'd1);
        repeat (8) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("pause_rst_hue", 32'(hue_state), 32'd0);
        chk("pause_rst_mode", 32'(mode), 32'd0);
        chk("pause_rst_duty_g", 32'(duty_g), 32'd10);
        chk("pause_rst_duty_b", 32'(duty_b), 32'd0);
        chk("pause_rst_tick", 32'(tick), 32'd0);
        repeat (30) cyc(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
